// File: rtl/apb_completer_regs.sv
// APB3/APB4 completer with a small byte-strobed register file and a fixed
// number of access-phase wait states. pready, pslverr and prdata are decoded
// from registered state only; protocol_err is a registered one-cycle pulse
// that appears in the cycle after the offending requester behaviour.
module apb_completer_regs #(
    parameter int unsigned ADDR_WIDTH  = 8,
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned NUM_REGS    = 16,
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    psel,
    input  logic                    penable,
    input  logic                    pwrite,
    input  logic [ADDR_WIDTH-1:0]   paddr,
    input  logic [DATA_WIDTH-1:0]   pwdata,
    input  logic [DATA_WIDTH/8-1:0] pstrb,
    output logic [DATA_WIDTH-1:0]   prdata,
    output logic                    pready,
    output logic                    pslverr,
    output logic                    protocol_err
);

    localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;
    localparam int unsigned IDX_WIDTH  = ADDR_WIDTH - 2;

    typedef enum logic [0:0] {
        StIdle,
        StAccess
    } state_e;

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic                    write_q, write_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [STRB_WIDTH-1:0]   strb_q, strb_d;
    logic [3:0]              wait_cnt_q, wait_cnt_d;
    logic                    prot_err_q, prot_err_d;

    logic [DATA_WIDTH-1:0]   regs_q [NUM_REGS];

    logic [IDX_WIDTH-1:0]    idx;
    logic                    addr_err;
    logic                    done;
    logic                    commit;
    logic                    mismatch;
    logic [DATA_WIDTH-1:0]   rd_word;

    // Decode of the latched transfer; the live bus is only compared, never used.
    assign idx      = addr_q[ADDR_WIDTH-1:2];
    assign addr_err = (32'(idx) >= NUM_REGS) || (addr_q[1:0] != 2'b00);

    // Completion cycle: in ACCESS with the wait counter exhausted.
    assign done     = (state_q == StAccess) && (wait_cnt_q == 4'd0);

    // Writes land only on a real completion edge with a legal address.
    assign commit   = done && psel && penable && write_q && !addr_err;

    assign mismatch = (paddr != addr_q) || (pwrite != write_q) || (pwdata != wdata_q);

    // Next-state logic: setup capture, wait countdown, abort and violation detection.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        write_d    = write_q;
        wdata_d    = wdata_q;
        strb_d     = strb_q;
        wait_cnt_d = wait_cnt_q;
        prot_err_d = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (penable) begin
                    // Access phase without a preceding setup phase.
                    prot_err_d = 1'b1;
                end else if (psel) begin
                    addr_d     = paddr;
                    write_d    = pwrite;
                    wdata_d    = pwdata;
                    strb_d     = pstrb;
                    wait_cnt_d = 4'(WAIT_CYCLES);
                    state_d    = StAccess;
                end
            end
            StAccess: begin
                if (!psel || !penable) begin
                    // Requester abandoned the transfer: drop it without writing.
                    prot_err_d = 1'b1;
                    state_d    = StIdle;
                end else begin
                    // Changed request fields are flagged but the latched copy still wins.
                    if (mismatch) begin
                        prot_err_d = 1'b1;
                    end
                    if (wait_cnt_q != 4'd0) begin
                        wait_cnt_d = wait_cnt_q - 4'd1;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Control and latched-request registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= StIdle;
            addr_q     <= '0;
            write_q    <= 1'b0;
            wdata_q    <= '0;
            strb_q     <= '0;
            wait_cnt_q <= 4'd0;
            prot_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            write_q    <= write_d;
            wdata_q    <= wdata_d;
            strb_q     <= strb_d;
            wait_cnt_q <= wait_cnt_d;
            prot_err_q <= prot_err_d;
        end
    end

    // Register file: byte-strobed commit on the completion edge; reset clears everything.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (commit) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                if (32'(idx) == i) begin
                    for (int unsigned b = 0; b < STRB_WIDTH; b++) begin
                        if (strb_q[b]) begin
                            regs_q[i][8*b +: 8] <= wdata_q[8*b +: 8];
                        end
                    end
                end
            end
        end
    end

    // Read mux over the register file using the latched index.
    always_comb begin
        rd_word = '0;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            if (32'(idx) == i) begin
                rd_word = regs_q[i];
            end
        end
    end

    // Outputs come from registered state only.
    always_comb begin
        pready       = done;
        pslverr      = done && addr_err;
        prdata       = (done && !write_q && !addr_err) ? rd_word : '0;
        protocol_err = prot_err_q;
    end

endmodule

// File: tb/tb_apb_completer_regs.sv
// Bench for apb_completer_regs: two instances (WAIT_CYCLES = 0 on bus 0,
// WAIT_CYCLES = 1 on bus 1). The driver pushes the expected completion cycle,
// read data and error flag into a per-bus queue; a negedge monitor pops and
// compares whenever a transfer completes.
module tb_apb_completer_regs;

    localparam int unsigned AW = 8;
    localparam int unsigned DW = 32;
    localparam int unsigned NR = 16;

    typedef struct packed {
        logic [31:0] cyc;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    logic          clock = 1'b0;
    logic          reset;
    logic          psel_v    [2];
    logic          penable_v [2];
    logic          pwrite_v  [2];
    logic [AW-1:0] paddr_v   [2];
    logic [DW-1:0] pwdata_v  [2];
    logic [3:0]    pstrb_v   [2];
    logic [DW-1:0] prdata_v  [2];
    logic          pready_v  [2];
    logic          pslverr_v [2];
    logic          perr_v    [2];

    int unsigned cyc = 0;
    int vectors = 0;
    int miscompares = 0;
    bit mon_en = 1'b0;
    int prot_cnt [2] = '{0, 0};
    int rdy_cnt  [2] = '{0, 0};
    exp_t exp_q0 [$];
    exp_t exp_q1 [$];

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    apb_completer_regs #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_REGS(NR), .WAIT_CYCLES(0)
    ) dut_w0 (
        .clock(clock), .reset(reset), .psel(psel_v[0]), .penable(penable_v[0]),
        .pwrite(pwrite_v[0]), .paddr(paddr_v[0]), .pwdata(pwdata_v[0]), .pstrb(pstrb_v[0]),
        .prdata(prdata_v[0]), .pready(pready_v[0]), .pslverr(pslverr_v[0]),
        .protocol_err(perr_v[0])
    );

    apb_completer_regs #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_REGS(NR), .WAIT_CYCLES(1)
    ) dut_w1 (
        .clock(clock), .reset(reset), .psel(psel_v[1]), .penable(penable_v[1]),
        .pwrite(pwrite_v[1]), .paddr(paddr_v[1]), .pwdata(pwdata_v[1]), .pstrb(pstrb_v[1]),
        .prdata(prdata_v[1]), .pready(pready_v[1]), .pslverr(pslverr_v[1]),
        .protocol_err(perr_v[1])
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic push(input int b, input exp_t e);
        if (b == 0) exp_q0.push_back(e);
        else        exp_q1.push_back(e);
    endtask

    // Scoreboard monitor: compares each completion against the queued expectation.
    always @(negedge clock) begin
        if (mon_en) begin
            for (int b = 0; b < 2; b++) begin
                exp_t e;
                bit   have;
                if (perr_v[b])  prot_cnt[b]++;
                if (pready_v[b]) rdy_cnt[b]++;
                if (psel_v[b] && penable_v[b] && pready_v[b]) begin
                    have = 1'b0;
                    if (b == 0 && exp_q0.size() > 0) begin
                        e = exp_q0.pop_front(); have = 1'b1;
                    end else if (b == 1 && exp_q1.size() > 0) begin
                        e = exp_q1.pop_front(); have = 1'b1;
                    end
                    if (!have) begin
                        vectors++;
                        miscompares++;
                        $display("FAIL bus%0d unexpected completion at cycle %0d", b, cyc);
                    end else begin
                        check($sformatf("bus%0d completion cycle", b), cyc, e.cyc);
                        check($sformatf("bus%0d prdata", b), prdata_v[b], e.rdata);
                        check($sformatf("bus%0d pslverr", b), 32'(pslverr_v[b]), 32'(e.err));
                    end
                end
                if (!pready_v[b]) begin
                    check($sformatf("bus%0d pslverr idle", b), 32'(pslverr_v[b]), 32'd0);
                    check($sformatf("bus%0d prdata idle", b), prdata_v[b], 32'd0);
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic idle(input int b);
        psel_v[b]    = 1'b0;
        penable_v[b] = 1'b0;
        pwrite_v[b]  = 1'b0;
    endtask

    // One APB transfer; called at posedge+1, returns at posedge+1 after completion
    // so a following call issues its setup phase with no idle gap.
    task automatic xfer(input int b, input bit wr, input logic [7:0] addr,
                        input logic [31:0] wdata, input logic [3:0] strb,
                        input logic [31:0] exp_rd, input bit exp_err, input bit glitch = 1'b0);
        exp_t e;
        int   n;
        psel_v[b]    = 1'b1;
        penable_v[b] = 1'b0;
        pwrite_v[b]  = wr;
        paddr_v[b]   = addr;
        pwdata_v[b]  = wdata;
        pstrb_v[b]   = strb;
        e.cyc   = cyc + 1 + ((b == 0) ? 0 : 1);
        e.rdata = exp_rd;
        e.err   = exp_err;
        push(b, e);
        tick(1);
        penable_v[b] = 1'b1;
        if (glitch) begin
            paddr_v[b]  = addr ^ 8'h0C;
            pwdata_v[b] = ~wdata;
        end
        n = 0;
        forever begin
            @(negedge clock);
            if (pready_v[b]) break;
            n++;
            if (n > 16) begin
                vectors++;
                miscompares++;
                $display("FAIL bus%0d timeout waiting for pready, got 0, expected 1", b);
                break;
            end
        end
        tick(1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        for (int b = 0; b < 2; b++) begin
            idle(b);
            paddr_v[b]  = '0;
            pwdata_v[b] = '0;
            pstrb_v[b]  = '0;
        end
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;

        // Reset state of both instances.
        @(negedge clock);
        for (int b = 0; b < 2; b++) begin
            check($sformatf("bus%0d reset pready", b), 32'(pready_v[b]), 32'd0);
            check($sformatf("bus%0d reset pslverr", b), 32'(pslverr_v[b]), 32'd0);
            check($sformatf("bus%0d reset prdata", b), prdata_v[b], 32'd0);
            check($sformatf("bus%0d reset protocol_err", b), 32'(perr_v[b]), 32'd0);
        end
        mon_en = 1'b1;
        tick(1);

        // Full write then immediate read-back.
        xfer(1, 1'b1, 8'h04, 32'hDEADBEEF, 4'hF, 32'h0, 1'b0);
        xfer(1, 1'b0, 8'h04, 32'h0, 4'h0, 32'hDEADBEEF, 1'b0);
        idle(1);
        tick(1);

        // Partial strobe write clears bytes 0 and 2 only.
        xfer(1, 1'b1, 8'h08, 32'hFFFFFFFF, 4'hF, 32'h0, 1'b0);
        xfer(1, 1'b1, 8'h08, 32'h00000000, 4'h5, 32'h0, 1'b0);
        xfer(1, 1'b0, 8'h08, 32'h0, 4'h0, 32'hFF00FF00, 1'b0);
        idle(1);
        tick(1);

        // Out-of-range and misaligned accesses error and touch nothing.
        xfer(1, 1'b1, 8'h40, 32'h11111111, 4'hF, 32'h0, 1'b1);
        xfer(1, 1'b0, 8'h41, 32'h0, 4'h0, 32'h0, 1'b1);
        xfer(1, 1'b1, 8'h06, 32'h22222222, 4'hF, 32'h0, 1'b1);
        xfer(1, 1'b0, 8'h00, 32'h0, 4'h0, 32'h0, 1'b0);
        xfer(1, 1'b0, 8'h04, 32'h0, 4'h0, 32'hDEADBEEF, 1'b0);
        xfer(1, 1'b0, 8'h08, 32'h0, 4'h0, 32'hFF00FF00, 1'b0);
        xfer(1, 1'b0, 8'h3C, 32'h0, 4'h0, 32'h0, 1'b0);
        idle(1);
        tick(1);

        // Zero-wait instance: back-to-back write and read with no gap.
        xfer(0, 1'b1, 8'h0C, 32'h12345678, 4'hF, 32'h0, 1'b0);
        xfer(0, 1'b0, 8'h0C, 32'h0, 4'h0, 32'h12345678, 1'b0);
        xfer(0, 1'b1, 8'h3C, 32'hA0B0C0D0, 4'hC, 32'h0, 1'b0);
        xfer(0, 1'b0, 8'h3C, 32'h0, 4'h0, 32'hA0B00000, 1'b0);
        idle(0);
        tick(2);
        check("bus0 protocol_err after legal traffic", 32'(prot_cnt[0]), 32'd0);
        check("bus1 protocol_err after legal traffic", 32'(prot_cnt[1]), 32'd0);

        // psel dropped in the wait cycle: abort, single protocol_err, no write.
        prot_cnt[1] = 0;
        rdy_cnt[1]  = 0;
        psel_v[1]    = 1'b1;
        penable_v[1] = 1'b0;
        pwrite_v[1]  = 1'b1;
        paddr_v[1]   = 8'h10;
        pwdata_v[1]  = 32'h55AA55AA;
        pstrb_v[1]   = 4'hF;
        tick(1);
        idle(1);
        tick(5);
        check("abort protocol_err pulses", 32'(prot_cnt[1]), 32'd1);
        check("abort pready cycles", 32'(rdy_cnt[1]), 32'd0);
        xfer(1, 1'b0, 8'h10, 32'h0, 4'h0, 32'h0, 1'b0);
        idle(1);
        tick(1);

        // penable alone while idle.
        prot_cnt[1] = 0;
        rdy_cnt[1]  = 0;
        penable_v[1] = 1'b1;
        tick(1);
        penable_v[1] = 1'b0;
        tick(4);
        check("lone penable protocol_err pulses", 32'(prot_cnt[1]), 32'd1);
        check("lone penable pready cycles", 32'(rdy_cnt[1]), 32'd0);

        // Address/data changed during access: flagged in both access cycles,
        // transfer still uses the latched address and data.
        prot_cnt[1] = 0;
        xfer(1, 1'b1, 8'h14, 32'hCAFEF00D, 4'hF, 32'h0, 1'b0, 1'b1);
        idle(1);
        tick(3);
        check("mismatch protocol_err cycles", 32'(prot_cnt[1]), 32'd2);
        xfer(1, 1'b0, 8'h14, 32'h0, 4'h0, 32'hCAFEF00D, 1'b0);
        xfer(1, 1'b0, 8'h18, 32'h0, 4'h0, 32'h0, 1'b0);
        idle(1);
        tick(1);

        // Reset during the access phase of a write.
        psel_v[1]    = 1'b1;
        penable_v[1] = 1'b0;
        pwrite_v[1]  = 1'b1;
        paddr_v[1]   = 8'h00;
        pwdata_v[1]  = 32'hA5A5A5A5;
        pstrb_v[1]   = 4'hF;
        tick(1);
        penable_v[1] = 1'b1;
        reset        = 1'b1;
        tick(1);
        reset = 1'b0;
        idle(1);
        @(negedge clock);
        check("pready after mid-transfer reset", 32'(pready_v[1]), 32'd0);
        tick(1);
        xfer(1, 1'b0, 8'h00, 32'h0, 4'h0, 32'h0, 1'b0);
        xfer(1, 1'b0, 8'h04, 32'h0, 4'h0, 32'h0, 1'b0);
        idle(1);
        tick(3);

        check("scoreboard drained", 32'(exp_q0.size() + exp_q1.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
